// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Wait-state counter: counts cycles within one half-word access, flags the final one.
module wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign last = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_sequencer.sv
// Splits each 32-bit load/store into two wait-stated half-word SRAM accesses,
// holding ready low for the whole transfer so the pipeline freezes.
module sram_access_sequencer
  import mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  state_t state, state_nxt;

  logic               req;
  logic               op_wr;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic [31:0]        offset;
  logic               unused_offset;
  logic               in_xfer;
  logic               half;
  logic               cnt_last;
  logic [SRAM_AW-1:0] xfer_addr;
  logic [15:0]        xfer_dq;
  logic [SRAM_AW-1:0] addr_hold;
  logic [15:0]        dq_hold;

  assign req    = rd_en | wr_en;
  assign offset = address - DATA_BASE;
  // Only the word bits that reach the SRAM are kept; byte offset and overflow drop out.
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

  wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (!in_xfer | cnt_last),
    .en  (in_xfer),
    .last(cnt_last)
  );

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    in_xfer   = 1'b0;
    half      = HALF_LO;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOW;
          ready     = 1'b0;
        end
      end
      LOW: begin
        in_xfer = 1'b1;
        ready   = 1'b0;
        if (cnt_last) state_nxt = HIGH;
      end
      HIGH: begin
        in_xfer = 1'b1;
        ready   = 1'b0;
        half    = HALF_HI;
        if (cnt_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer_addr = {word_q, half};
  assign xfer_dq   = (half == HALF_HI) ? wdata_q[31:16] : wdata_q[15:0];

  // Address/data follow the transfer live and otherwise hold the last driven value.
  assign sram_addr   = in_xfer ? xfer_addr : addr_hold;
  assign sram_dq_out = in_xfer ? xfer_dq : dq_hold;
  assign sram_dq_oe  = in_xfer & op_wr;
  assign sram_we_n   = !(in_xfer & op_wr & !cnt_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      addr_hold <= '0;
      dq_hold   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        word_q  <= offset[SRAM_AW:2];
        wdata_q <= write_data;
        op_wr   <= wr_en;
      end
      if (in_xfer) begin
        addr_hold <= xfer_addr;
        dq_hold   <= xfer_dq;
        if (!op_wr && cnt_last) begin
          if (half == HALF_HI) read_data[31:16] <= sram_dq_in;
          else                 read_data[15:0]  <= sram_dq_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with a behavioural 16-bit SRAM.
module tb_sram_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  sram_access_sequencer #(
    .WAIT_CYCLES(5),
    .DATA_BASE  (32'd1024),
    .SRAM_AW    (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr[5:0]];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Per-access observations
  int          lows, wel_lo, wel_hi, oe_cnt;
  logic [17:0] lo_addr, hi_addr;
  logic [15:0] lo_dat, hi_dat;
  logic [31:0] done_rdata;

  // Presents a request and follows it to the DONE cycle; request stays asserted.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    lows = 0; wel_lo = 0; wel_hi = 0; oe_cnt = 0;
    lo_addr = '1; hi_addr = '1; lo_dat = '1; hi_dat = '1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!ready) begin
        lows++;
        if (sram_dq_oe) oe_cnt++;
        if (!sram_we_n) begin
          if (sram_addr[0] == 1'b0) begin
            wel_lo++; lo_addr = sram_addr; lo_dat = sram_dq_out;
          end else begin
            wel_hi++; hi_addr = sram_addr; hi_dat = sram_dq_out;
          end
        end
      end else begin
        done = 1;
        done_rdata = read_data;
      end
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  int total_lows;

  initial begin
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; address = 32'd1028; write_data = '0;

    // Reset held with a pending load
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
      check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
      check("rst_rdata", read_data, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("idle_addr", {14'd0, sram_addr}, 32'd0);

    // Store 0xDEADBEEF to 1028
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check("st_lows", lows, 11);
    check("st_wel_lo", wel_lo, 4);
    check("st_wel_hi", wel_hi, 4);
    check("st_oe", oe_cnt, 10);
    check("st_lo_addr", {14'd0, lo_addr}, 32'd2);
    check("st_lo_dat", {16'd0, lo_dat}, 32'h0000BEEF);
    check("st_hi_addr", {14'd0, hi_addr}, 32'd3);
    check("st_hi_dat", {16'd0, hi_dat}, 32'h0000DEAD);
    check("st_rdata_held", done_rdata, 32'd0);
    check("st_mem", {mem[3], mem[2]}, 32'hDEADBEEF);
    go_idle();
    @(negedge clk);
    check("post_st_ready", {31'd0, ready}, 32'd1);
    check("post_st_addr_hold", {14'd0, sram_addr}, 32'd3);

    // Load back
    do_access(1'b1, 1'b0, 32'd1028, 32'd0);
    check("ld_lows", lows, 11);
    check("ld_we", wel_lo + wel_hi, 0);
    check("ld_oe", oe_cnt, 0);
    check("ld_rdata", done_rdata, 32'hDEADBEEF);
    go_idle();

    // Back-to-back store then load at 1024
    do_access(1'b0, 1'b1, 32'd1024, 32'h12345678);
    total_lows = lows;
    check("b2b_st_lo_addr", {14'd0, lo_addr}, 32'd0);
    check("b2b_st_hi_addr", {14'd0, hi_addr}, 32'd1);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0);
    total_lows += lows;
    check("b2b_ld_lows", lows, 11);
    check("b2b_total_lows", total_lows, 22);
    check("b2b_rdata", done_rdata, 32'h12345678);
    go_idle();

    // Simultaneous rd/wr is a write
    do_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
    check("both_mem4", {16'd0, mem[4]}, 32'h00005A5A);
    check("both_mem5", {16'd0, mem[5]}, 32'h0000A5A5);
    check("both_rdata", done_rdata, 32'h12345678);
    check("both_we", wel_lo + wel_hi, 8);
    go_idle();

    // Reset in the third cycle of HIGH during a store
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1028; write_data = 32'h11112222;
    for (int c = 0; c < 8; c++) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("mid_hi_addr", {14'd0, sram_addr}, 32'd3);
    check("mid_hi_we_n", {31'd0, sram_we_n}, 32'd0);
    @(posedge clk); #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    rst = 1'b1;

    do_access(1'b1, 1'b0, 32'd1028, 32'd0);
    check("rl_lows", lows, 11);
    check("rl_rdata", done_rdata, 32'h11112222);
    go_idle();
    @(negedge clk);
    check("end_ready", {31'd0, ready}, 32'd1);
    check("end_we_n", {31'd0, sram_we_n}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
